// File: rtl/exp4_fluxo_dados_jogo_pkg.sv
// Shared constants for the sequence-memory game datapath: widths, default
// timeout length and the fixed 16x4 sequence ROM.
package exp4_fluxo_dados_jogo_pkg;

   localparam int unsigned AddrWidth = 4;
   localparam int unsigned DataWidth = 4;
   localparam int unsigned TimeoutCiclosDefault = 5000;

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;

   // Sequence words, address 15 on the left down to address 0 on the right.
   localparam logic [15:0][DataWidth-1:0] Rom = {
      4'b0100, 4'b0001, 4'b1000, 4'b1000,
      4'b0100, 4'b0100, 4'b0010, 4'b0010,
      4'b0001, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0100, 4'b0010, 4'b0001
   };

   function automatic data_t rom_read(input addr_t addr);
      return Rom[addr];
   endfunction

endpackage

// File: rtl/exp4_fluxo_dados_jogo_if.sv
// Control/status bundle between the game FSM (master) and the datapath (slave).
interface exp4_fluxo_dados_jogo_if;
   import exp4_fluxo_dados_jogo_pkg::*;

   logic  zeraC;
   logic  contaC;
   logic  zeraR;
   logic  registraR;
   data_t chaves;
   logic  botao;
   logic  fimC;
   logic  igual;
   logic  jogada_feita;
   logic  timeout;
   addr_t db_contagem;
   data_t db_memoria;
   data_t db_jogada;

   modport master (
      output zeraC, contaC, zeraR, registraR, chaves, botao,
      input  fimC, igual, jogada_feita, timeout, db_contagem, db_memoria, db_jogada
   );

   modport slave (
      input  zeraC, contaC, zeraR, registraR, chaves, botao,
      output fimC, igual, jogada_feita, timeout, db_contagem, db_memoria, db_jogada
   );

endinterface

// File: rtl/exp4_detector_borda.sv
// Rising-edge detector: one-cycle pulse for each 0->1 transition of a level
// input that is already synchronous to clock.
module exp4_detector_borda (
   input  logic clock,
   input  logic reset,
   input  logic sinal,
   output logic borda
);

   logic sinal_ant;

   // Remember the previous level of the input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sinal_ant <= 1'b0;
      else       sinal_ant <= sinal;
   end

   // Pulse is combinational so it is visible in the same cycle as the rise.
   always_comb begin
      borda = sinal & ~sinal_ant;
   end

endmodule

// File: rtl/exp4_fluxo_dados_jogo.sv
// Datapath for the sequence-memory game: round address counter, sequence ROM,
// play register, comparator and play-button edge detector.
// Optional idle timeout is built only when TIMEOUT_EN is defined; otherwise the
// timeout output is tied low.
module exp4_fluxo_dados_jogo
   import exp4_fluxo_dados_jogo_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = TimeoutCiclosDefault
) (
   input logic                    clock,
   input logic                    reset,
   exp4_fluxo_dados_jogo_if.slave bus
);

   addr_t contagem;
   data_t jogada;
   data_t memoria;
   logic  jogada_feita;

   // Address counter: clear has priority over increment; wraps 15 -> 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)           contagem <= '0;
      else if (bus.zeraC)  contagem <= '0;
      else if (bus.contaC) contagem <= contagem + addr_t'(1);
   end

   // Play register: clear has priority over load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)              jogada <= '0;
      else if (bus.zeraR)     jogada <= '0;
      else if (bus.registraR) jogada <= bus.chaves;
   end

   // ROM lookup and comparison are purely combinational.
   always_comb begin
      memoria = rom_read(contagem);
   end

   exp4_detector_borda u_detector_borda (
      .clock (clock),
      .reset (reset),
      .sinal (bus.botao),
      .borda (jogada_feita)
   );

`ifdef TIMEOUT_EN
   localparam logic [15:0] OciosoMax = 16'(TIMEOUT_CICLOS - 1);

   logic [15:0] ocioso;

   // Idle counter: any player/FSM activity restarts it; saturates at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                        ocioso <= '0;
      else if (bus.zeraC | bus.registraR | jogada_feita) ocioso <= '0;
      else if (ocioso != OciosoMax)                     ocioso <= ocioso + 16'd1;
   end

   // Timeout flag follows the saturated counter.
   always_comb begin
      bus.timeout = (ocioso == OciosoMax);
   end
`else
   // No idle counter; the parameter is only meaningful with the feature built.
   always_comb begin
      bus.timeout = (TIMEOUT_CICLOS == 0) & 1'b0;
   end
`endif

   // Status and debug outputs are direct views of internal state.
   always_comb begin
      bus.fimC         = (contagem == addr_t'(15));
      bus.igual        = (jogada == memoria);
      bus.jogada_feita = jogada_feita;
      bus.db_contagem  = contagem;
      bus.db_memoria   = memoria;
      bus.db_jogada    = jogada;
   end

endmodule

// File: tb/tb_exp4_fluxo_dados_jogo.sv
// Self-checking bench for exp4_fluxo_dados_jogo. An independent cycle model
// predicts every output; predictions go through a scoreboard queue and are
// compared against the DUT before each rising edge. Honours TIMEOUT_EN.
module tb_exp4_fluxo_dados_jogo;

   localparam int unsigned ToCiclos = 8;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } sb_t;

   logic clock;
   logic reset;

   exp4_fluxo_dados_jogo_if bus ();

   exp4_fluxo_dados_jogo #(
      .TIMEOUT_CICLOS (ToCiclos)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   sb_t         sb[$];
   int          n_cmp;
   int          n_bad;
   int          pulsos;
   logic [3:0]  rom_tb [16];
   logic [3:0]  m_cnt;
   logic [3:0]  m_reg;
   logic        m_prev;
   logic [15:0] m_idle;

   // Expected output vector {fimC, igual, jogada_feita, timeout, contagem, memoria, jogada}.
   function automatic logic [15:0] model_vec();
      logic [3:0] mem;
      logic       jf;
      logic       to;
      mem = rom_tb[m_cnt];
      jf  = bus.botao & ~m_prev;
`ifdef TIMEOUT_EN
      to = (m_idle == 16'(ToCiclos - 1));
`else
      to = 1'b0;
`endif
      return {(m_cnt == 4'd15), (m_reg == mem), jf, to, m_cnt, mem, m_reg};
   endfunction

   task automatic push_expected(input string tag);
      sb_t e;
      e.tag = tag;
      e.v   = model_vec();
      sb.push_back(e);
   endtask

   task automatic pop_compare();
      sb_t         e;
      logic [15:0] obs;
      e   = sb.pop_front();
      obs = {bus.fimC, bus.igual, bus.jogada_feita, bus.timeout,
             bus.db_contagem, bus.db_memoria, bus.db_jogada};
      n_cmp++;
      assert (obs === e.v) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
   endtask

   task automatic model_reset();
      m_cnt  = '0;
      m_reg  = '0;
      m_prev = 1'b0;
      m_idle = '0;
   endtask

   // One clock cycle: drive after the falling edge, check, then advance the model.
   task automatic step(input logic zc, input logic cc, input logic zr, input logic rr,
                       input logic [3:0] ch, input logic bt, input string tag);
      logic jf;
      @(negedge clock);
      bus.zeraC     = zc;
      bus.contaC    = cc;
      bus.zeraR     = zr;
      bus.registraR = rr;
      bus.chaves    = ch;
      bus.botao     = bt;
      #1;
      push_expected(tag);
      pop_compare();
      pulsos += int'(bus.jogada_feita);
      @(posedge clock);
      jf = bt & ~m_prev;
      if (zc)      m_cnt = '0;
      else if (cc) m_cnt = m_cnt + 4'd1;
      if (zr)      m_reg = '0;
      else if (rr) m_reg = ch;
      if (zc | rr | jf)                     m_idle = '0;
      else if (m_idle != 16'(ToCiclos - 1)) m_idle = m_idle + 16'd1;
      m_prev = bt;
   endtask

   initial begin
      rom_tb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
      n_cmp  = 0;
      n_bad  = 0;
      pulsos = 0;
      model_reset();
      bus.zeraC     = 1'b0;
      bus.contaC    = 1'b0;
      bus.zeraR     = 1'b0;
      bus.registraR = 1'b0;
      bus.chaves    = 4'b0000;
      bus.botao     = 1'b0;
      reset         = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      push_expected("reset_state");
      pop_compare();

      // Clear wins over increment.
      step(1, 1, 0, 0, 4'b0000, 0, "zera_conta");
      step(0, 0, 0, 0, 4'b0000, 0, "apos_zera");

      // Count to 15, then wrap.
      for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 4'b0000, 0, "conta");
      step(0, 0, 0, 0, 4'b0000, 0, "fim_15");
      step(0, 1, 0, 0, 4'b0000, 0, "conta_wrap");
      step(0, 0, 0, 0, 4'b0000, 0, "wrap_0");

      // Register and compare at address 2.
      step(1, 0, 0, 0, 4'b0000, 0, "zera_c");
      step(0, 1, 0, 0, 4'b0000, 0, "conta_1");
      step(0, 1, 0, 0, 4'b0000, 0, "conta_2");
      step(0, 0, 0, 1, 4'b0100, 0, "registra_0100");
      step(0, 0, 0, 0, 4'b0100, 0, "igual_1");
      step(0, 0, 0, 1, 4'b1000, 0, "registra_1000");
      step(0, 0, 0, 0, 4'b1000, 0, "igual_0");
      step(0, 0, 1, 0, 4'b1000, 0, "zera_r");
      step(0, 0, 0, 0, 4'b1000, 0, "jogada_0");

      // Button held high 10 cycles, released, pressed again.
      pulsos = 0;
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'b0000, 1, "botao_alto");
      for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 4'b0000, 0, "botao_baixo");
      for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 4'b0000, 1, "botao_alto2");
      step(0, 0, 0, 0, 4'b0000, 0, "botao_solto");
      n_cmp++;
      assert (pulsos === 2) else begin
         n_bad++;
         $error("FAIL pulse_count observed=%0d expected=2", pulsos);
      end

      // All four controls together.
      step(0, 1, 0, 1, 4'b0010, 0, "pre_todos");
      step(1, 1, 1, 1, 4'b1000, 0, "todos");
      step(0, 0, 0, 0, 4'b0000, 0, "apos_todos");

      // Asynchronous reset at counter=7, register=0010.
      step(1, 0, 0, 0, 4'b0000, 0, "zera_c2");
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 4'b0000, 0, "conta_7");
      step(0, 0, 0, 1, 4'b0010, 0, "registra_0010");
      step(0, 0, 0, 0, 4'b0000, 0, "estado_7");
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      push_expected("reset_async");
      pop_compare();
      #3;
      reset = 1'b0;
      step(0, 0, 0, 0, 4'b0000, 0, "apos_reset");

      // Idle timeout: clear, wait, then clear via registraR.
      step(1, 0, 0, 0, 4'b0000, 0, "to_zera");
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'b0000, 0, "to_ocioso");
      step(0, 0, 0, 1, 4'b0001, 0, "to_registra");
      step(0, 0, 0, 0, 4'b0001, 0, "to_limpo");
      step(0, 0, 0, 0, 4'b0001, 0, "to_limpo2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
